updown_sweep_ctrl: RTL

Direction controller for the parameterised `up_down_counter`. It watches the counter's count and drives the counter's `up_down` input so the count sweeps back and forth between two programmable limits. It also reports turn-around events and keeps a count of completed sweeps. It sits directly upstream of the counter and shares its clock and reset, closing a feedback loop: counter `out` -> `count_in`, `up_down` -> counter `up_down`.

---
 rtl/updown_sweep_ctrl_pkg.sv | 16 +
 rtl/updown_sweep_ctrl_sat_counter.sv | 19 +
 rtl/updown_sweep_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/updown_sweep_ctrl_pkg.sv
// Shared constants for the up/down sweep controller: FSM state codes and
// counter direction levels.
package updown_sweep_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_RUN_UP = 3'd2;
    localparam state_t ST_RUN_DN = 3'd3;
    localparam state_t ST_ERR    = 3'd4;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/updown_sweep_ctrl_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [SW-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != {SW{1'b1}})) begin
            q <= q + {{(SW-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Direction controller that keeps an external up/down counter sweeping
// between two latched limits, with turn pulses and a sweep count.
module updown_sweep_ctrl
    import updown_sweep_ctrl_pkg::*;
#(
    parameter int N  = 5,
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  count_in,
    input  logic [N-1:0]  lo_lim,
    input  logic [N-1:0]  hi_lim,
    output logic          up_down,
    output logic          turn_hi,
    output logic          turn_lo,
    output logic [SW-1:0] sweeps,
    output logic          cfg_err
);

    // state   | meaning
    // IDLE    | counter free-runs, up_down held
    // LOAD    | latch limits, pick initial direction
    // RUN_UP  | counting up toward hi_q
    // RUN_DN  | counting down toward lo_q
    // ERR     | latched limits illegal, wait for en low

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state;
    logic [N-1:0] lo_q;
    logic [N-1:0] hi_q;
    logic [N-1:0] nxt;
    logic         sweep_inc;

    // Value the counter lands on at the coming edge.
    assign nxt       = up_down ? (count_in + ONE) : (count_in - ONE);
    assign sweep_inc = (state == ST_RUN_DN) && en && (count_in == (lo_q + ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            up_down <= DIR_UP;
            turn_hi <= 1'b0;
            turn_lo <= 1'b0;
            cfg_err <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            turn_hi <= 1'b0;
            turn_lo <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else begin
                        lo_q <= lo_lim;
                        hi_q <= hi_lim;
                        if (lo_lim >= hi_lim) begin
                            state   <= ST_ERR;
                            cfg_err <= 1'b1;
                        end else if (nxt < hi_lim) begin
                            up_down <= DIR_UP;
                            state   <= ST_RUN_UP;
                        end else begin
                            up_down <= DIR_DN;
                            state   <= ST_RUN_DN;
                        end
                    end
                end
                ST_RUN_UP: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (count_in == (hi_q - ONE)) begin
                        // Counter reaches hi_q on this edge; reverse from the next one.
                        up_down <= DIR_DN;
                        turn_hi <= 1'b1;
                        state   <= ST_RUN_DN;
                    end
                end
                ST_RUN_DN: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (sweep_inc) begin
                        up_down <= DIR_UP;
                        turn_lo <= 1'b1;
                        state   <= ST_RUN_UP;
                    end
                end
                ST_ERR: begin
                    if (!en) begin
                        state   <= ST_IDLE;
                        cfg_err <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cfg_err <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.SW(SW)) u_sweeps (
        .clk (clk),
        .rst (rst),
        .inc (sweep_inc),
        .q   (sweeps)
    );

endmodule
